sp_ctl_mc: RTL
==============

# sp_ctl_mc

Parametrised multi-cycle controller for the SP processor: fetches, decodes and executes the 32-bit SP instruction set against an external combinational ALU and a variable-latency memory port. It supersedes the fixed-latency, fixed-width controller. Data width, address width and start PC are configurable. Memory uses a req/gnt/rvalid handshake, and halt, busy and optional performance-counter status are exposed to the top level.

## Interface
- DATA_W, 32: register, ALU and memory data width (≥16).
- ADDR_W, 16: PC and memory address width (≤DATA_W).
- RESET_PC, 0: PC loaded on reset and on every start.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data (instruction uses low 32 bits).
- opcode  out  5  current opcode to ALU.
- alu0, alu1  out  DATA_W  ALU operands (signed).
- aluout  in  DATA_W  combinational ALU result.
- busy  out  1  high in any state except IDLE/HALT.
- halted  out  1  high in HALT.
- instr_count, cycle_count  out  DATA_W  performance counters (see Configuration).

## Operation
- Instruction: [29:25] opcode, [24:22] dst, [21:19] src0, [18:16] src1, [15:0] imm, sign-extended to DATA_W.
- Register index 0 reads 0; index 1 reads imm; indices 2–7 are GPRs. Writes to 0/1 are dropped.
- States: IDLE → (start) FETCH → FWAIT → DEC → OPR → EXEC → {MEM → MWAIT} → WB → FETCH; HLT goes to HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Held stable until mem_gnt, then FWAIT.
- FWAIT: on mem_rvalid, capture inst and go to DEC.
- DEC: latch opcode, dst, src0, src1 and imm.
- OPR: for LHI, alu0=R[dst] and alu1=imm; otherwise alu0=R[src0] and alu1=R[src1].
- EXEC: capture aluout. LD/ST go to MEM; HLT goes to HALT; all other opcodes go to WB.
- MEM: mem_addr=alu1[ADDR_W-1:0], mem_we=(ST), mem_wdata=alu0. Held until mem_gnt. ST then goes to WB; LD goes to MWAIT.
- MWAIT: on mem_rvalid, capture load data, then WB.
- WB:
  - ADD..LHI (0–7): R[dst]=aluout; pc+1.
  - LD (8): R[dst]=load data; pc+1.
  - ST (9): pc+1.
  - JLT..JNE (16–19): if aluout≠0, r7=pc and pc=imm[ADDR_W-1:0]; else pc+1.
  - JIN (20): r7=pc; pc=alu0[ADDR_W-1:0].
  - Undefined opcodes: NOP, pc+1.
- pc arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0.
- HALT: stays there; start → FETCH with pc=RESET_PC and GPRs preserved.
- start outside IDLE/HALT is ignored.
- mem_rvalid outside FWAIT/MWAIT is ignored, including a stale response after reset.

## Timing
- Reset values:
  - FSM = IDLE, pc = RESET_PC.
  - GPRs, inst, opcode, alu0, alu1 and counters = 0.
  - mem_req = mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = halted = 0.
- Reset mid-transaction drops mem_req the next cycle and abandons the instruction.
- Zero-wait memory (gnt with req, rvalid one cycle later) gives these latencies:
  - ALU op or jump: 6 cycles.
  - ST: 7 cycles.
  - LD: 8 cycles.
- Each memory wait cycle adds one cycle.
- mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_gnt=0.
- Register writes land at the WB clock edge and are visible to the next instruction's OPR.

## Configuration
- SP_CTL_PERF_EN defined:
  - cycle_count increments every busy cycle.
  - instr_count increments on each WB and on entry to HALT.
  - Both counters wrap modulo 2^DATA_W and clear on reset and on start.
- SP_CTL_PERF_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package sp_pkg holds:
  - the opcode constants (ADD=0, SUB=1, LSF=2, RSF=3, AND=4, OR=5, XOR=6, LHI=7, LD=8, ST=9, JLT=16, JLE=17, JEQ=18, JNE=19, JIN=20, HLT=24);
  - the FSM state enum;
  - the instruction field bit positions.
- Sub-module sp_regfile (r2–r7, DATA_W wide) has two combinational read ports (index 1 returns the imm input) and one write port gated by a write enable.

## Test plan
- Reset, then start with zero-wait memory, running ADD r2=r1+r0 with imm=5 then HLT: r2=5, halted=1, and the first instruction takes 6 cycles.
- LD r3 from address 0x10 holding 0xDEADBEEF with a 3-cycle rvalid delay, then ST r3 to 0x11: memory[0x11]=0xDEADBEEF, and mem_addr stays stable through the stalls.
- JEQ taken at pc=4 to imm=0x20: pc=0x20 and r7=4. With the branch not taken: pc=5 and r7 unchanged.
- ADDR_W=8 with the instruction at 0xFF, a non-jump: next fetch address is 0x00. Then LHI with dst=r4 (holding 0x1234) and imm=0xABCD: r4 equals the ALU result.
- Reset asserted while in FWAIT, then a stale rvalid arrives: FSM stays in IDLE, mem_req=0 and registers are zeroed. start after HALT refetches from RESET_PC.
- With SP_CTL_PERF_EN, a 3-instruction program ending in HLT: instr_count=3. Without the macro: both counters read 0.

Source files
------------

// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_pkg
// Brief    : Shared definitions for the SP multi-cycle controller: opcode
//            constants, controller state encoding and instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
package sp_pkg;

  // Opcodes
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_LSF = 5'd2;
  localparam logic [4:0] OP_RSF = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_LHI = 5'd7;
  localparam logic [4:0] OP_LD  = 5'd8;
  localparam logic [4:0] OP_ST  = 5'd9;
  localparam logic [4:0] OP_JLT = 5'd16;
  localparam logic [4:0] OP_JLE = 5'd17;
  localparam logic [4:0] OP_JEQ = 5'd18;
  localparam logic [4:0] OP_JNE = 5'd19;
  localparam logic [4:0] OP_JIN = 5'd20;
  localparam logic [4:0] OP_HLT = 5'd24;

  // Instruction field bit positions
  localparam int OPC_HI  = 29;
  localparam int OPC_LO  = 25;
  localparam int DST_HI  = 24;
  localparam int DST_LO  = 22;
  localparam int SRC0_HI = 21;
  localparam int SRC0_LO = 19;
  localparam int SRC1_HI = 18;
  localparam int SRC1_LO = 16;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  // Controller states
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_FWAIT = 4'd2,
    S_DEC   = 4'd3,
    S_OPR   = 4'd4,
    S_EXEC  = 4'd5,
    S_MEM   = 4'd6,
    S_MWAIT = 4'd7,
    S_WB    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  // Conditional jumps JLT..JNE share the "branch if ALU result nonzero" rule
  function automatic logic is_jcc(input logic [4:0] op);
    return (op >= OP_JLT) && (op <= OP_JNE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sp_regfile
// Brief    : SP register file. Index 0 reads zero, index 1 reads the current
//            immediate, indices 2..7 are general-purpose registers. Writes to
//            0 and 1 are discarded.
// Revision : 1.0 - initial release
// ============================================================================
module sp_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ra_i,
  input  logic [2:0]        rb_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              we_i,
  input  logic [2:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [2:7];

  // GPR storage: cleared on reset, written only for indices 2..7
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 2; i <= 7; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i >= 3'd2)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read port A with the zero/immediate aliases
  always_comb begin
    rd_a_o = '0;
    case (ra_i)
      3'd0:    rd_a_o = '0;
      3'd1:    rd_a_o = imm_i;
      default: rd_a_o = regs_q[ra_i];
    endcase
  end

  // Read port B with the zero/immediate aliases
  always_comb begin
    rd_b_o = '0;
    case (rb_i)
      3'd0:    rd_b_o = '0;
      3'd1:    rd_b_o = imm_i;
      default: rd_b_o = regs_q[rb_i];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sp_ctl_mc.sv
`default_nettype none
// ============================================================================
// Module   : sp_ctl_mc
// Brief    : Multi-cycle SP controller: fetch/decode/execute against an
//            external combinational ALU and a req/gnt/rvalid memory port.
//            Optional performance counters are built when SP_CTL_PERF_EN is
//            defined; otherwise instr_count/cycle_count are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ctl_mc #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [4:0]        opcode,
  output logic [DATA_W-1:0] alu0,
  output logic [DATA_W-1:0] alu1,
  input  logic [DATA_W-1:0] aluout,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] instr_count,
  output logic [DATA_W-1:0] cycle_count
);
  import sp_pkg::*;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q;
  logic [4:0]        opc_q;
  logic [2:0]        dst_q, src0_q, src1_q;
  logic [DATA_W-1:0] imm_q, alu0_q, alu1_q, res_q, ld_q;
  logic [DATA_W-1:0] rd_a, rd_b, rf_wd;
  logic [2:0]        rf_ra, rf_wa;
  logic              rf_we, start_ok, jump_taken, w_unused;

  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign jump_taken = (is_jcc(opc_q) && (res_q != '0)) || (opc_q == OP_JIN);
  assign rf_ra      = (opc_q == OP_LHI) ? dst_q : src0_q;
  assign rf_we      = (state_q == S_WB) &&
                      ((opc_q <= OP_LHI) || (opc_q == OP_LD) || jump_taken);
  assign rf_wa      = jump_taken ? 3'd7 : dst_q;
  assign rf_wd      = jump_taken ? DATA_W'(pc_q) :
                      (opc_q == OP_LD) ? ld_q : res_q;
  assign opcode     = opc_q;
  assign alu0       = alu0_q;
  assign alu1       = alu1_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);
  assign w_unused   = ^inst_q[31:30];

  sp_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .ra_i   (rf_ra),
    .rb_i   (src1_q),
    .imm_i  (imm_q),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .we_i   (rf_we),
    .wa_i   (rf_wa),
    .wd_i   (rf_wd)
  );

  // Next PC at write-back: taken branch, indirect jump, or sequential (wraps)
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (opc_q == OP_JIN)
      pc_d = alu0_q[ADDR_W-1:0];
    else if (is_jcc(opc_q) && (res_q != '0))
      pc_d = imm_q[ADDR_W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and memory port drive; address/data come from registers
  // that are frozen while a request waits for grant
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_gnt) state_d = S_FWAIT;
      end
      S_FWAIT: if (mem_rvalid) state_d = S_DEC;
      S_DEC:   state_d = S_OPR;
      S_OPR:   state_d = S_EXEC;
      S_EXEC: begin
        if ((opc_q == OP_LD) || (opc_q == OP_ST)) state_d = S_MEM;
        else if (opc_q == OP_HLT)                 state_d = S_HALT;
        else                                      state_d = S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (opc_q == OP_ST);
        mem_addr  = alu1_q[ADDR_W-1:0];
        mem_wdata = alu0_q;
        if (mem_gnt) state_d = (opc_q == OP_ST) ? S_WB : S_MWAIT;
      end
      S_MWAIT: if (mem_rvalid) state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers, each updated only in its owning state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= PC_INIT;
      inst_q <= '0;
      opc_q  <= '0;
      dst_q  <= '0;
      src0_q <= '0;
      src1_q <= '0;
      imm_q  <= '0;
      alu0_q <= '0;
      alu1_q <= '0;
      res_q  <= '0;
      ld_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: if (start_ok) pc_q <= PC_INIT;
        S_FWAIT: if (mem_rvalid) inst_q <= 32'(mem_rdata);
        S_DEC: begin
          opc_q  <= inst_q[OPC_HI:OPC_LO];
          dst_q  <= inst_q[DST_HI:DST_LO];
          src0_q <= inst_q[SRC0_HI:SRC0_LO];
          src1_q <= inst_q[SRC1_HI:SRC1_LO];
          imm_q  <= DATA_W'($signed(inst_q[IMM_HI:IMM_LO]));
        end
        S_OPR: begin
          alu0_q <= rd_a;
          alu1_q <= (opc_q == OP_LHI) ? imm_q : rd_b;
        end
        S_EXEC:  res_q <= aluout;
        S_MWAIT: if (mem_rvalid) ld_q <= mem_rdata;
        S_WB:    pc_q <= pc_d;
        default: ;
      endcase
    end
  end

`ifdef SP_CTL_PERF_EN
  logic [DATA_W-1:0] icnt_q, ccnt_q;

  // Retired-instruction and busy-cycle counters, cleared by reset or start
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (busy) ccnt_q <= ccnt_q + DATA_W'(1);
      if ((state_q == S_WB) || ((state_q == S_EXEC) && (opc_q == OP_HLT)))
        icnt_q <= icnt_q + DATA_W'(1);
    end
  end

  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule
`default_nettype wire
